button_press_encoder: RTL and testbench

- Input front end for the hit-the-light game. It conditions the four raw push-buttons: synchronises, debounces and detects press edges on each one.
- It presents one press event at a time to the game/hit-check logic as a button index. The event is held until the consumer acknowledges it.
- It is the producer side of the button-to-game interface. The game drives `lights`; this block returns which button the player struck.

---
 rtl/button_press_encoder_pkg.sv | 27 ++
 rtl/button_press_encoder_debounce.sv | 63 ++++++
 rtl/button_press_encoder.sv | 130 +++++++++++++
 tb/tb_button_press_encoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/button_press_encoder_pkg.sv
// Shared constants and helpers for the hit-the-light button front end.
// The game top and the hit-check logic use the same debounce constant.
package button_press_encoder_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int CNT_W_DEFAULT           = 20;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    function automatic logic [1:0] lowest_idx(input logic [3:0] vec);
        logic [1:0] idx;
        casez (vec)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] vec);
        return {2'b00, vec[0]} + {2'b00, vec[1]} + {2'b00, vec[2]} + {2'b00, vec[3]};
    endfunction

endpackage

// File: rtl/button_press_encoder_debounce.sv
// Single-button conditioner: 2-flop synchroniser, polarity fix and
// stability counter. rise pulses on the edge where stable goes 0->1.
module button_debounce
    import button_press_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable,
    output logic rise
);

    // Raw level of a released button; also the inversion mask after sync.
    localparam logic RELEASED_RAW_C = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;
    logic             sync_s;
    logic             differ_s;
    logic             at_limit_s;
    logic             rise_s;

    // Polarity-corrected level and change-acceptance decode.
    always_comb begin
        sync_s     = sync2_r ^ RELEASED_RAW_C;
        differ_s   = sync_s ^ stable_r;
        at_limit_s = (cnt_r == CNT_LAST_C);
        rise_s     = differ_s & at_limit_s & sync_s;
    end

    // Synchroniser, stability counter and accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r  <= RELEASED_RAW_C;
            sync2_r  <= RELEASED_RAW_C;
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (!differ_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (at_limit_s) begin
                stable_r <= sync_s;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE_C;
            end
        end
    end

    assign stable = stable_r;
    assign rise   = rise_s;

endmodule

// File: rtl/button_press_encoder.sv
// Button front end: debounces four keys and presents one press event at a
// time (index + multi flag) until the game acknowledges it.
module button_press_encoder
    import button_press_encoder_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   press_ack,
    output logic                   press_valid,
    output logic [1:0]             press_idx,
    output logic                   press_multi,
    output logic [NUM_BUTTONS-1:0] stable
);

    logic [NUM_BUTTONS-1:0] stable_s;
    logic [NUM_BUTTONS-1:0] rise_s;

    logic [0:0]             state_r;
    logic [NUM_BUTTONS-1:0] pending_r;
    logic [NUM_BUTTONS-1:0] taken_r;
    logic                   press_valid_r;
    logic [1:0]             press_idx_r;
    logic                   press_multi_r;

    logic [0:0]             state_nxt_s;
    logic [NUM_BUTTONS-1:0] pending_nxt_s;
    logic [NUM_BUTTONS-1:0] taken_nxt_s;
    logic                   valid_nxt_s;
    logic [1:0]             idx_nxt_s;
    logic                   multi_nxt_s;
    logic                   clr_taken_s;

    genvar gi;
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (buttons[gi]),
            .stable  (stable_s[gi]),
            .rise    (rise_s[gi])
        );
    end

    // Event FSM: latch lowest pending press, hold until ack or enable drops.
    always_comb begin
        state_nxt_s = state_r;
        taken_nxt_s = taken_r;
        valid_nxt_s = press_valid_r;
        idx_nxt_s   = press_idx_r;
        multi_nxt_s = press_multi_r;
        clr_taken_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && (pending_r != {NUM_BUTTONS{1'b0}})) begin
                    idx_nxt_s   = lowest_idx(pending_r);
                    multi_nxt_s = (popcount4(pending_r) > 3'd1);
                    taken_nxt_s = pending_r;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_PRESENT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (!enable) begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else if (press_ack) begin
                    valid_nxt_s = 1'b0;
                    clr_taken_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pending set/clear; a fresh press edge wins over the ack clear.
    always_comb begin
        pending_nxt_s = pending_r;
        if (!enable) begin
            pending_nxt_s = {NUM_BUTTONS{1'b0}};
        end else if (clr_taken_s) begin
            pending_nxt_s = (pending_r & ~taken_r) | rise_s;
        end else begin
            pending_nxt_s = pending_r | rise_s;
        end
    end

    // Event and FSM state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            pending_r     <= {NUM_BUTTONS{1'b0}};
            taken_r       <= {NUM_BUTTONS{1'b0}};
            press_valid_r <= 1'b0;
            press_idx_r   <= 2'd0;
            press_multi_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pending_r     <= pending_nxt_s;
            taken_r       <= taken_nxt_s;
            press_valid_r <= valid_nxt_s;
            press_idx_r   <= idx_nxt_s;
            press_multi_r <= multi_nxt_s;
        end
    end

    assign press_valid = press_valid_r;
    assign press_idx   = press_idx_r;
    assign press_multi = press_multi_r;
    assign stable      = stable_s;

endmodule

// File: tb/tb_button_press_encoder.sv
// Directed bench for button_press_encoder with a short debounce window.
module tb_button_press_encoder;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] buttons;
    logic       press_ack;
    logic       press_valid;
    logic [1:0] press_idx;
    logic       press_multi;
    logic [3:0] stable;

    int n_total;
    int n_pass;

    button_press_encoder #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .buttons     (buttons),
        .press_ack   (press_ack),
        .press_valid (press_valid),
        .press_idx   (press_idx),
        .press_multi (press_multi),
        .stable      (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        press_ack = 1'b1;
        wait_neg(1);
        press_ack = 1'b0;
    endtask

    initial begin
        logic seen;
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b0;
        enable    = 1'b1;
        buttons   = 4'b1111;
        press_ack = 1'b0;
        #12;
        check_eq("rst_valid", press_valid, 1'b0);
        check_eq("rst_idx", press_idx, 2'd0);
        check_eq("rst_multi", press_multi, 1'b0);
        check_eq("rst_stable", stable, 4'b0000);
        wait_neg(1);
        rst = 1'b1;
        wait_neg(2);

        // 1: single press of button 1
        buttons = 4'b1101;
        wait_neg(5);
        check_eq("s1_stable_e4", stable, 4'b0000);
        wait_neg(1);
        check_eq("s1_stable_e5", stable, 4'b0010);
        check_eq("s1_valid_e5", press_valid, 1'b0);
        wait_neg(1);
        check_eq("s1_valid_e6", press_valid, 1'b1);
        check_eq("s1_idx", press_idx, 2'd1);
        check_eq("s1_multi", press_multi, 1'b0);
        ack_pulse();
        check_eq("s1_valid_ack", press_valid, 1'b0);
        buttons = 4'b1111;
        wait_neg(8);
        check_eq("s1_release", stable, 4'b0000);
        check_eq("s1_no_event", press_valid, 1'b0);

        // 2: three-cycle glitch on button 0
        buttons = 4'b1110;
        wait_neg(3);
        buttons = 4'b1111;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_neg(1);
            if (stable != 4'b0000 || press_valid) seen = 1'b1;
        end
        check_eq("s2_glitch", seen, 1'b0);

        // 3: buttons 3 and 2 together
        buttons = 4'b0011;
        wait_neg(7);
        check_eq("s3_valid", press_valid, 1'b1);
        check_eq("s3_idx", press_idx, 2'd2);
        check_eq("s3_multi", press_multi, 1'b1);
        ack_pulse();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_neg(1);
            if (press_valid) seen = 1'b1;
        end
        check_eq("s3_discarded", seen, 1'b0);
        buttons = 4'b1111;
        wait_neg(8);

        // 4: press 0, then 3 during PRESENT
        buttons = 4'b1110;
        wait_neg(7);
        check_eq("s4_valid0", press_valid, 1'b1);
        check_eq("s4_idx0", press_idx, 2'd0);
        buttons = 4'b0110;
        wait_neg(8);
        check_eq("s4_stable", stable, 4'b1001);
        check_eq("s4_hold_idx", press_idx, 2'd0);
        check_eq("s4_hold_valid", press_valid, 1'b1);
        ack_pulse();
        check_eq("s4_gap", press_valid, 1'b0);
        wait_neg(1);
        check_eq("s4_valid3", press_valid, 1'b1);
        check_eq("s4_idx3", press_idx, 2'd3);
        check_eq("s4_multi3", press_multi, 1'b0);
        ack_pulse();
        buttons = 4'b1111;
        wait_neg(8);

        // 5: press while disabled is not an event
        enable  = 1'b0;
        buttons = 4'b1011;
        wait_neg(7);
        check_eq("s5_stable", stable, 4'b0100);
        check_eq("s5_no_valid", press_valid, 1'b0);
        enable = 1'b1;
        wait_neg(4);
        check_eq("s5_enable_held", press_valid, 1'b0);
        buttons = 4'b1111;
        wait_neg(7);
        check_eq("s5_released", stable, 4'b0000);
        buttons = 4'b1011;
        wait_neg(7);
        check_eq("s5_valid", press_valid, 1'b1);
        check_eq("s5_idx", press_idx, 2'd2);
        ack_pulse();
        buttons = 4'b1111;
        wait_neg(8);

        // 6: asynchronous reset mid-event
        buttons = 4'b1101;
        wait_neg(7);
        check_eq("s6_valid_pre", press_valid, 1'b1);
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check_eq("s6_async_drop", press_valid, 1'b0);
        check_eq("s6_async_stable", stable, 4'b0000);
        wait_neg(2);
        rst = 1'b1;
        wait_neg(7);
        check_eq("s6_stable_held", stable, 4'b0010);
        enable = 1'b1;
        wait_neg(4);
        check_eq("s6_no_event", press_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
